// File: rtl/irq_ctrl.sv
// Interrupt controller for the single-cycle MIPS core: edge-latched requests, fixed priority,
// PC redirect into a handler vector on entry and back to the saved EPC on RES.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | no handler running; waits for eligible request at a boundary
// S_ENTER  | one cycle: redirect PC to the handler vector of irq_id
// S_SERVICE| handler running; new requests only accumulate in pending
// S_EXIT   | one cycle: redirect PC back to epc
module irq_ctrl #(
   parameter int          NUM_IRQ    = 4,
   parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
   parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_IRQ-1:0] irq_req,
   input  logic               we_mask,
   input  logic [NUM_IRQ-1:0] mask_wd,
   input  logic               instr_boundary,
   input  logic [31:0]        pc_next,
   input  logic               irq_resume,
   output logic               pc_redirect,
   output logic [31:0]        redirect_addr,
   output logic               in_service,
   output logic [2:0]         irq_id,
   output logic [31:0]        epc,
   output logic [NUM_IRQ-1:0] pending,
   output logic [NUM_IRQ-1:0] mask
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ENTER   = 2'd1,
      S_SERVICE = 2'd2,
      S_EXIT    = 2'd3
   } state_t;

   state_t             state;
   logic [NUM_IRQ-1:0] req_q;
   logic               armed;
   logic [NUM_IRQ-1:0] rise;
   logic [NUM_IRQ-1:0] eligible;
   logic [NUM_IRQ-1:0] clr_vec;
   logic [2:0]         winner;
   logic               take;
   logic [31:0]        vec_addr;

   // The first cycle after reset only samples the lines, so a level already
   // high when reset releases is not mistaken for a fresh request.
   assign rise     = armed ? (irq_req & ~req_q) : '0;
   assign eligible = pending & ~mask;
   assign take     = (state == S_IDLE) && (|eligible) && instr_boundary;
   assign vec_addr = VEC_BASE + VEC_STRIDE * {29'd0, winner};

   always_comb begin
      winner = 3'd0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (eligible[i]) winner = 3'(i);
      end
   end

   always_comb begin
      clr_vec = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         clr_vec[i] = take && (winner == 3'(i));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q   <= '0;
         armed   <= 1'b0;
         pending <= '0;
         mask    <= '1;
      end else begin
         req_q   <= irq_req;
         armed   <= 1'b1;
         // a rise on the line being taken wins over its clear
         pending <= (pending & ~clr_vec) | rise;
         if (we_mask) mask <= mask_wd;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         epc           <= 32'd0;
         irq_id        <= 3'd0;
         pc_redirect   <= 1'b0;
         redirect_addr <= 32'd0;
         in_service    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (take) begin
                  state         <= S_ENTER;
                  epc           <= pc_next;
                  irq_id        <= winner;
                  pc_redirect   <= 1'b1;
                  redirect_addr <= vec_addr;
                  in_service    <= 1'b1;
               end
            end
            S_ENTER: begin
               state         <= S_SERVICE;
               pc_redirect   <= 1'b0;
               redirect_addr <= 32'd0;
            end
            S_SERVICE: begin
               if (irq_resume && instr_boundary) begin
                  state         <= S_EXIT;
                  pc_redirect   <= 1'b1;
                  redirect_addr <= epc;
               end
            end
            S_EXIT: begin
               state         <= S_IDLE;
               pc_redirect   <= 1'b0;
               redirect_addr <= 32'd0;
               in_service    <= 1'b0;
            end
            default: begin
               state         <= S_IDLE;
               pc_redirect   <= 1'b0;
               redirect_addr <= 32'd0;
               in_service    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: reset, single entry/resume, priority without nesting,
// masking, boundary gating and reset during service.
module tb_irq_ctrl;

   logic        clk;
   logic        rst_n;
   logic [3:0]  irq_req;
   logic        we_mask;
   logic [3:0]  mask_wd;
   logic        instr_boundary;
   logic [31:0] pc_next;
   logic        irq_resume;
   logic        pc_redirect;
   logic [31:0] redirect_addr;
   logic        in_service;
   logic [2:0]  irq_id;
   logic [31:0] epc;
   logic [3:0]  pending;
   logic [3:0]  mask;

   int n_cmp  = 0;
   int n_fail = 0;

   irq_ctrl #(
      .NUM_IRQ   (4),
      .VEC_BASE  (32'h0000_0100),
      .VEC_STRIDE(32'h0000_0010)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .irq_req       (irq_req),
      .we_mask       (we_mask),
      .mask_wd       (mask_wd),
      .instr_boundary(instr_boundary),
      .pc_next       (pc_next),
      .irq_resume    (irq_resume),
      .pc_redirect   (pc_redirect),
      .redirect_addr (redirect_addr),
      .in_service    (in_service),
      .irq_id        (irq_id),
      .epc           (epc),
      .pending       (pending),
      .mask          (mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic redir, input logic [31:0] addr,
                          input logic insvc);
      chk({tag, ".pc_redirect"}, {31'd0, pc_redirect}, {31'd0, redir});
      chk({tag, ".redirect_addr"}, redirect_addr, addr);
      chk({tag, ".in_service"}, {31'd0, in_service}, {31'd0, insvc});
   endtask

   initial begin
      rst_n = 1'b0; irq_req = 4'b0001; we_mask = 1'b0; mask_wd = 4'h0;
      instr_boundary = 1'b0; pc_next = 32'd0; irq_resume = 1'b0;

      // reset with line 0 held high
      tick(); tick();
      chk_out("rst", 1'b0, 32'd0, 1'b0);
      chk("rst.irq_id", {29'd0, irq_id}, 32'd0);
      chk("rst.epc", epc, 32'd0);
      chk("rst.pending", {28'd0, pending}, 32'd0);
      chk("rst.mask", {28'd0, mask}, 32'h0000_000F);
      rst_n = 1'b1;
      tick();
      we_mask = 1'b1; mask_wd = 4'h0; instr_boundary = 1'b1;
      tick();
      we_mask = 1'b0;
      chk("unmask.mask", {28'd0, mask}, 32'd0);
      tick(); tick();
      chk("held_level.pending", {28'd0, pending}, 32'd0);
      chk("held_level.in_service", {31'd0, in_service}, 32'd0);
      irq_req = 4'b0000;
      tick();

      // single request on line 2
      irq_req = 4'b0100; pc_next = 32'h0000_0040;
      tick();
      chk("single.pending_set", {28'd0, pending}, 32'h4);
      chk("single.still_idle", {31'd0, in_service}, 32'd0);
      tick();
      pc_next = 32'h0000_0044;
      chk_out("single.enter", 1'b1, 32'h0000_0120, 1'b1);
      chk("single.epc", epc, 32'h0000_0040);
      chk("single.irq_id", {29'd0, irq_id}, 32'd2);
      chk("single.pending_clr", {28'd0, pending}, 32'd0);
      tick();
      chk_out("single.service", 1'b0, 32'd0, 1'b1);
      tick();
      chk_out("single.service2", 1'b0, 32'd0, 1'b1);
      chk("single.level_no_rereq", {28'd0, pending}, 32'd0);
      irq_resume = 1'b1; instr_boundary = 1'b0;
      tick();
      chk_out("resume_no_boundary", 1'b0, 32'd0, 1'b1);
      instr_boundary = 1'b1;
      tick();
      irq_resume = 1'b0;
      chk_out("single.exit", 1'b1, 32'h0000_0040, 1'b1);
      chk("single.exit_id", {29'd0, irq_id}, 32'd2);
      tick();
      chk_out("single.idle", 1'b0, 32'd0, 1'b0);
      chk("single.epc_hold", epc, 32'h0000_0040);
      irq_req = 4'b0000;
      tick();

      // simultaneous rises on lines 3 and 1, line 0 arrives during service
      irq_req = 4'b1010; pc_next = 32'h0000_0200;
      tick();
      chk("prio.pending", {28'd0, pending}, 32'hA);
      tick();
      chk_out("prio.enter1", 1'b1, 32'h0000_0110, 1'b1);
      chk("prio.id1", {29'd0, irq_id}, 32'd1);
      chk("prio.pending_after1", {28'd0, pending}, 32'h8);
      chk("prio.epc1", epc, 32'h0000_0200);
      tick();
      irq_req = 4'b1011;
      tick();
      chk("prio.nest_pending", {28'd0, pending}, 32'h9);
      chk_out("prio.no_nest", 1'b0, 32'd0, 1'b1);
      chk("prio.no_nest_id", {29'd0, irq_id}, 32'd1);
      irq_resume = 1'b1;
      tick();
      irq_resume = 1'b0; pc_next = 32'h0000_0300;
      chk_out("prio.exit1", 1'b1, 32'h0000_0200, 1'b1);
      tick();
      chk_out("prio.gap_idle", 1'b0, 32'd0, 1'b0);
      tick();
      irq_req = 4'b0000;
      chk_out("prio.enter0", 1'b1, 32'h0000_0100, 1'b1);
      chk("prio.id0", {29'd0, irq_id}, 32'd0);
      chk("prio.epc0", epc, 32'h0000_0300);
      chk("prio.pending_after0", {28'd0, pending}, 32'h8);
      tick();
      irq_resume = 1'b1;
      tick();
      irq_resume = 1'b0;
      chk_out("prio.exit0", 1'b1, 32'h0000_0300, 1'b1);
      tick();
      chk_out("prio.gap_idle2", 1'b0, 32'd0, 1'b0);
      tick();
      chk_out("prio.enter3", 1'b1, 32'h0000_0130, 1'b1);
      chk("prio.id3", {29'd0, irq_id}, 32'd3);
      chk("prio.pending_empty", {28'd0, pending}, 32'd0);
      tick();
      irq_resume = 1'b1;
      tick();
      irq_resume = 1'b0;
      tick();
      chk_out("prio.idle_end", 1'b0, 32'd0, 1'b0);

      // masking
      we_mask = 1'b1; mask_wd = 4'b0010;
      tick();
      we_mask = 1'b0;
      irq_req = 4'b0010;
      tick(); tick(); tick();
      chk("mask.pending_held", {28'd0, pending}, 32'h2);
      chk_out("mask.no_enter", 1'b0, 32'd0, 1'b0);
      we_mask = 1'b1; mask_wd = 4'b0000;
      tick();
      we_mask = 1'b0;
      chk_out("mask.write_cycle", 1'b0, 32'd0, 1'b0);
      tick();
      chk_out("mask.enter", 1'b1, 32'h0000_0110, 1'b1);
      chk("mask.id", {29'd0, irq_id}, 32'd1);
      tick();
      irq_resume = 1'b1;
      tick();
      irq_resume = 1'b0; irq_req = 4'b0000;
      tick();
      chk_out("mask.idle_end", 1'b0, 32'd0, 1'b0);

      // boundary gating, then reset during service
      instr_boundary = 1'b0; irq_req = 4'b0001;
      tick();
      chk("gate.pending", {28'd0, pending}, 32'h1);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_out("gate.wait", 1'b0, 32'd0, 1'b0);
      end
      instr_boundary = 1'b1; pc_next = 32'h0000_0500;
      tick();
      chk_out("gate.enter", 1'b1, 32'h0000_0100, 1'b1);
      chk("gate.epc", epc, 32'h0000_0500);
      tick();
      chk_out("gate.service", 1'b0, 32'd0, 1'b1);
      rst_n = 1'b0;
      #1;
      chk_out("midrst", 1'b0, 32'd0, 1'b0);
      chk("midrst.epc", epc, 32'd0);
      chk("midrst.pending", {28'd0, pending}, 32'd0);
      chk("midrst.mask", {28'd0, mask}, 32'h0000_000F);
      chk("midrst.irq_id", {29'd0, irq_id}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick(); tick();
      chk_out("postrst.idle", 1'b0, 32'd0, 1'b0);
      chk("postrst.pending", {28'd0, pending}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
